// File: rtl/ysyx_idu_ibuf.sv
// ysyx_idu_ibuf: circular instruction buffer between IFU and decoder.
// Optional same-cycle bypass when empty: define YSYX_IBUF_BYPASS_EN.
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif

module ysyx_idu_ibuf #(
    parameter int XLEN  = `YSYX_XLEN,
    parameter int DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         prev_valid,
    output logic                         out_ready,
    input  logic [31:0]                  inst,
    input  logic [XLEN-1:0]              pc,
    input  logic [XLEN-1:0]              pnpc,
    input  logic                         fault,
    output logic                         out_valid,
    input  logic                         next_ready,
    output logic [31:0]                  out_inst,
    output logic [XLEN-1:0]              out_pc,
    output logic [XLEN-1:0]              out_pnpc,
    output logic                         out_fault,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pnpc;
        logic            fault;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        in_e;
    entry_t        out_e;
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          rdy_q;
    logic          bypass;
    logic          enq;
    logic          deq;
    logic          wr;
    logic          rd;

    assign in_e = '{inst: inst, pc: pc, pnpc: pnpc, fault: fault};

`ifdef YSYX_IBUF_BYPASS_EN
    assign bypass = (cnt == '0) && prev_valid && !flush;
    assign out_e  = bypass ? in_e : mem[head];
`else
    assign bypass = 1'b0;
    assign out_e  = mem[head];
`endif

    assign out_ready = rdy_q;
    assign out_valid = ((cnt != '0) && !flush) || bypass;
    assign enq       = prev_valid && rdy_q && !flush;
    assign deq       = out_valid && next_ready;
    // A bypassed entry taken the same cycle never touches storage.
    assign wr        = enq && !(bypass && next_ready);
    assign rd        = deq && !bypass;

    assign out_inst  = out_valid ? out_e.inst : 32'd0;
    assign out_fault = out_valid ? out_e.fault : 1'b0;
    assign out_pc    = out_e.pc;
    assign out_pnpc  = out_e.pnpc;
    assign count     = cnt;

    // Next occupancy; flush wins over any handshake.
    always_comb begin
        cnt_nxt = cnt;
        unique case (1'b1)
            flush:                cnt_nxt = '0;
            !flush && wr && !rd:  cnt_nxt = cnt + CW'(1);
            !flush && rd && !wr:  cnt_nxt = cnt - CW'(1);
            default:              cnt_nxt = cnt;
        endcase
    end

    // Pointers, occupancy and the registered ready.
    always_ff @(posedge clock) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            cnt   <= '0;
            rdy_q <= 1'b1;
        end else begin
            cnt   <= cnt_nxt;
            rdy_q <= (cnt_nxt < CW'(DEPTH));
            if (flush) begin
                head <= '0;
                tail <= '0;
            end else begin
                if (wr) tail <= tail + AW'(1);
                if (rd) head <= head + AW'(1);
            end
        end
    end

    // Entry storage; contents need no reset.
    always_ff @(posedge clock) begin
        if (wr) mem[tail] <= in_e;
    end

    // Overflow and underflow guards.
    always_ff @(posedge clock) begin
        if (reset) begin
            assert (!(enq && cnt == CW'(DEPTH)));
            assert (!(deq && cnt == '0 && !bypass));
        end
    end

endmodule

// File: doc/ysyx_idu_ibuf.md
# ysyx_idu_ibuf

Parametrised instruction buffer that decouples fetch from decode. It holds up to `DEPTH` fetched entries, each carrying `{inst, pc, pnpc, fault}`, in a circular FIFO and presents them in order to the decoder through a valid/ready handshake. It replaces the single-entry IDU input latch, adding multi-entry buffering, a registered `out_ready` that does not depend combinationally on `next_ready`, an explicit flush, and an occupancy output. It sits between the IFU and `ysyx_idu_decoder`.

## Interface
Parameters:
- `XLEN`, default `` `YSYX_XLEN ``: width of `pc` and `pnpc`.
- `DEPTH`, default 4: number of entries. Must be a power of two and ≥ 2.

Ports:
- `clock`, in, 1: the block's single clock.
- `reset`, in, 1: synchronous, active-low reset. When `reset == 0` at a `clock` edge, the block resets.
- `flush`, in, 1: discards all entries. Driven on redirect or trap.
- `prev_valid`, in, 1: the upstream entry is valid.
- `out_ready`, out, 1: the buffer can accept an entry this cycle.
- `inst`, in, 32: fetched instruction.
- `pc`, in, `XLEN`: instruction PC.
- `pnpc`, in, `XLEN`: predicted next PC.
- `fault`, in, 1: fetch access fault for this entry.
- `out_valid`, out, 1: the head entry is valid.
- `next_ready`, in, 1: downstream accepts the head entry.
- `out_inst`, out, 32: head instruction. Equals 0 when `out_valid == 0`.
- `out_pc`, out, `XLEN`: head PC.
- `out_pnpc`, out, `XLEN`: head predicted next PC.
- `out_fault`, out, 1: head fault flag. Equals 0 when `out_valid == 0`.
- `count`, out, `$clog2(DEPTH+1)`: current occupancy.

## Operation
- Storage is `DEPTH` entries, each `32 + 2*XLEN + 1` bits.
- Pointers:
  - `head` and `tail` are `$clog2(DEPTH)` bits wide and wrap naturally modulo `DEPTH`.
  - `count` is tracked separately.
- Enqueue condition: `enq = prev_valid && out_ready && !flush`. On enqueue, write the entry at `tail` and increment `tail`.
- Dequeue condition: `deq = out_valid && next_ready`. On dequeue, increment `head`.
- Count update: `count` next value = `count + enq − deq`. Simultaneous enqueue and dequeue leaves `count` unchanged.
- `out_ready` is registered and equals `(count_next < DEPTH)`. It therefore depends only on state. When full, no enqueue is accepted even if a dequeue occurs in the same cycle.
- `out_valid` equals `(count != 0) && !flush`, plus the bypass case described in Configuration.
- Output data are taken from the entry at `head`. `out_inst` and `out_fault` are forced to 0 when not valid, which yields a decoder bubble.
- Flush:
  - Sets `head = tail = 0` and `count = 0`.
  - Has priority over `enq` and `deq` in the same cycle. The incoming entry is dropped and no dequeue handshake completes.
- Reset, applied at any time including mid-operation, clears all state exactly like a flush. Storage contents are don't-care.
- Overflow and underflow are impossible by construction. The assertions `!(enq && count==DEPTH)` and `!(deq && count==0 && !bypass)` must hold.

## Timing
- Reset values:
  - `out_valid = 0`
  - `out_ready = 1`
  - `count = 0`
  - `out_inst = 0`
  - `out_fault = 0`
  - `out_pc` and `out_pnpc` are don't-care.
- Latency without bypass: an entry enqueued at edge N is presented with `out_valid = 1` in the cycle after edge N. Minimum latency is 1 cycle.
- Throughput: 1 entry per cycle sustained when `DEPTH ≥ 2` and `next_ready` is held high.
- Backpressure:
  - `out_ready` falls in the cycle after the edge at which `count` reaches `DEPTH`.
  - `out_ready` rises in the cycle after the first dequeue from full.
- Flush effects are visible in the cycle after the flush edge: `count = 0` and `out_ready = 1`. During the flush cycle itself, `out_valid` is already 0.

## Configuration
- Macro: `YSYX_IBUF_BYPASS_EN`.
- When defined:
  - If `count == 0`, `prev_valid == 1` and `!flush`, then `out_valid = 1` and the `out_*` signals are driven combinationally from the inputs, giving 0-cycle latency.
  - If `next_ready` is also high, the entry is consumed directly and is not written, so `count` stays 0.
  - Otherwise the entry is written normally.
- When undefined: no combinational input-to-output path exists, and every entry takes at least 1 cycle.

## Test plan
- Reset: hold `reset = 0` for 2 cycles with random inputs. Required: `out_valid = 0`, `out_ready = 1`, `count = 0`, `out_inst = 0`.
- Single pass (bypass off): push `inst = 0x00500093`, `pc = 0x80000000`, with `next_ready = 1`. Required: the entry appears one cycle later with `out_pc = 0x80000000`, then `count` returns to 0. With bypass on, it appears in the same cycle and `count` stays 0.
- Fill and backpressure (`DEPTH = 4`, `next_ready = 0`): push 5 entries. Required: `count = 4`, `out_ready = 0` after the 4th, and the 5th is held upstream. Then set `next_ready = 1`. Required: all 5 drain in order.
- Simultaneous push and pop at `count = 2`. Required: `count` stays 2 and PC order is preserved.
- Flush with 3 entries and `prev_valid = 1`. Required: next cycle `count = 0`, `out_valid = 0`, the incoming entry is dropped, and the next push after the flush is the first entry out.
- Wrap-around: 11 pushes and pops with random `next_ready`. Required: PC sequence `0x80000000 + 4k` is preserved and `fault` bits stay aligned to their entries.
